// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side bus slave: one-hot state
// encodings, default bus widths and the legal read-latency range.
package mem_bus_pkg;

   localparam int ADDR_BUS_WIDTH = 8;
   localparam int MEM_WIDTH      = 32;
   localparam int RD_LAT_MIN     = 1;
   localparam int RD_LAT_MAX     = 4;
   localparam int TMR_W          = $clog2(RD_LAT_MAX + 1);

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_ADDR  = 5'b00010,
      S_WRITE = 5'b00100,
      S_RWAIT = 5'b01000,
      S_DONE  = 5'b10000
   } state_e;

   // Out-of-range latencies are clamped so the timer can never be loaded past its width.
   function automatic logic [TMR_W-1:0] lat_load(input int lat);
      if (lat < RD_LAT_MIN) return TMR_W'(RD_LAT_MIN);
      if (lat > RD_LAT_MAX) return TMR_W'(RD_LAT_MAX);
      return TMR_W'(lat);
   endfunction

endpackage

// File: rtl/rd_lat_timer.sv
// Read-latency timer: loads the latency, counts down while enabled and flags
// expiry at zero. Reloaded once per read beat.
module rd_lat_timer
   import mem_bus_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             expired_o
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_slave.sv
// Memory-side slave stage between the system bus FSM and the 32-bit memory.
// Define MEM_BUS_BURST_EN to add the bus_burst port and multi-beat accesses.
module mem_bus_slave
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W    = ADDR_BUS_WIDTH,
   parameter int DATA_W    = MEM_WIDTH,
   parameter int RD_LAT    = 1,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ale_en,
   input  logic              bus_read_en,
   input  logic              bus_write_en,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_wdata,
`ifdef MEM_BUS_BURST_EN
   input  logic              bus_burst,
`endif
   output logic [DATA_W-1:0] bus_rdata,
   output logic              bus_rvalid,
   output logic              bus_ready,
   output logic              bus_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              burst_q, burst_d, burst_req, last_beat;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d, err_q, err_d;
   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              tmr_load, tmr_dec, tmr_expired;

`ifdef MEM_BUS_BURST_EN
   assign burst_req = bus_burst;
`else
   assign burst_req = 1'b0;
`endif

   assign next_addr = addr_q + 1'b1;
   assign last_beat = !burst_q || (beat_q == BEAT_LAST);

   rd_lat_timer u_rd_lat_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .dec_i      (tmr_dec),
      .load_val_i (lat_load(RD_LAT)),
      .expired_o  (tmr_expired)
   );

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      beat_d      = beat_q;
      burst_d     = burst_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      err_d       = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tmr_load    = 1'b0;
      tmr_dec     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (ale_en) begin
               addr_d  = bus_addr;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (ale_en) begin
               addr_d = bus_addr;
            end else if (bus_write_en && bus_read_en) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (bus_write_en) begin
               burst_d     = burst_req;
               beat_d      = '0;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = bus_wdata;
               state_d     = S_WRITE;
            end else if (bus_read_en) begin
               burst_d    = burst_req;
               beat_d     = '0;
               mem_en_d   = 1'b1;
               mem_addr_d = addr_q;
               tmr_load   = 1'b1;
               state_d    = S_RWAIT;
            end
         end
         S_WRITE: begin
            // Next beat is issued only while the bus keeps write_en high; otherwise stall.
            if (last_beat) begin
               state_d = S_DONE;
            end else if (bus_write_en) begin
               addr_d      = next_addr;
               beat_d      = beat_q + 1'b1;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = next_addr;
               mem_wdata_d = bus_wdata;
            end
         end
         S_RWAIT: begin
            if (tmr_expired) begin
               rdata_d  = mem_rdata;
               rvalid_d = 1'b1;
               if (last_beat) begin
                  state_d = S_DONE;
               end else begin
                  addr_d     = next_addr;
                  beat_d     = beat_q + 1'b1;
                  mem_en_d   = 1'b1;
                  mem_addr_d = next_addr;
                  tmr_load   = 1'b1;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_DONE: begin
            if (ale_en) begin
               addr_d  = bus_addr;
               state_d = S_ADDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         beat_q      <= '0;
         burst_q     <= 1'b0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         beat_q      <= beat_d;
         burst_q     <= burst_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         err_q       <= err_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign bus_rdata  = rdata_q;
   assign bus_rvalid = rvalid_q;
   assign bus_err    = err_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
